msm_result_buffer: RTL and testbench

//   Result buffer on the far side of the MSM controller's padd interface. Captures each

---
 rtl/msm_result_buffer.sv | 136 +++++++++++++
 tb/tb_msm_result_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/msm_result_buffer.sv
// Result FIFO behind the point-adder: stores {bucket id, sum} per padd_out_vld and returns
// the oldest entry on rb_r_req through a registered read port, with occupancy and error status.
module msm_result_buffer #(
    parameter int WIDTH_ID     = 2,
    parameter int WIDTH_DATA   = 384,
    parameter int DEPTH        = 32,
    parameter int AFULL_MARGIN = 21
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        padd_out_vld,
    input  logic [WIDTH_ID-1:0]         padd_out_id,
    input  logic [WIDTH_DATA-1:0]       padd_out_data,
    input  logic                        rb_r_req,
    output logic                        rb_status,
    output logic [WIDTH_ID-1:0]         id_o_rb,
    output logic                        rb_rd_vld,
    output logic [WIDTH_ID-1:0]         rb_rd_id,
    output logic [WIDTH_DATA-1:0]       rb_rd_data,
    output logic                        rb_afull,
    output logic                        rb_full,
    output logic [$clog2(DEPTH):0]      rb_count,
    output logic                        err_ovf,
    output logic                        err_udf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH_ID + WIDTH_DATA;

    logic [EW-1:0]         mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [WIDTH_ID-1:0]   rd_id_q, rd_id_d;
    logic [WIDTH_DATA-1:0] rd_data_q, rd_data_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_udf_q, err_udf_d;

    logic                  empty;
    logic                  full;
    logic                  pop_ok;
    logic                  push_ok;
    logic [EW-1:0]         head;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign head   = mem_q[rd_ptr_q];

    // A pop frees the slot a same-cycle push lands in, so full does not block a push then.
    assign pop_ok  = !flush && rb_r_req && !empty;
    assign push_ok = !flush && padd_out_vld && (!full || pop_ok);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_vld_d  = pop_ok;
        rd_id_d   = rd_id_q;
        rd_data_d = rd_data_q;
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            rd_vld_d  = 1'b0;
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                rd_id_d   = head[EW-1 -: WIDTH_ID];
                rd_data_d = head[WIDTH_DATA-1:0];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (padd_out_vld && full && !pop_ok) begin
                err_ovf_d = 1'b1;
            end
            if (rb_r_req && empty) begin
                err_udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_vld_q  <= 1'b0;
            rd_id_q   <= '0;
            rd_data_q <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_vld_q  <= rd_vld_d;
            rd_id_q   <= rd_id_d;
            rd_data_q <= rd_data_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    // Storage is deliberately unreset; the head peek is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {padd_out_id, padd_out_data};
        end
    end

    assign rb_status  = !empty;
    assign id_o_rb    = empty ? '0 : head[EW-1 -: WIDTH_ID];
    assign rb_rd_vld  = rd_vld_q;
    assign rb_rd_id   = rd_id_q;
    assign rb_rd_data = rd_data_q;
    assign rb_afull   = (count_q >= CW'(DEPTH - AFULL_MARGIN));
    assign rb_full    = full;
    assign rb_count   = count_q;
    assign err_ovf    = err_ovf_q;
    assign err_udf    = err_udf_q;

endmodule

// File: tb/tb_msm_result_buffer.sv
// Directed bench for msm_result_buffer: ordering, full/afull, simultaneous push/pop,
// underflow, wrap streaming, flush and asynchronous reset.
module tb_msm_result_buffer;

    localparam int WID = 2;
    localparam int WD  = 384;
    localparam int DEP = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           padd_out_vld = 1'b0;
    logic [WID-1:0] padd_out_id = '0;
    logic [WD-1:0]  padd_out_data = '0;
    logic           rb_r_req = 1'b0;
    logic           rb_status;
    logic [WID-1:0] id_o_rb;
    logic           rb_rd_vld;
    logic [WID-1:0] rb_rd_id;
    logic [WD-1:0]  rb_rd_data;
    logic           rb_afull;
    logic           rb_full;
    logic [5:0]     rb_count;
    logic           err_ovf;
    logic           err_udf;

    int errors = 0;
    int checks = 0;

    msm_result_buffer #(.WIDTH_ID(WID), .WIDTH_DATA(WD), .DEPTH(DEP), .AFULL_MARGIN(21)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .padd_out_vld(padd_out_vld), .padd_out_id(padd_out_id), .padd_out_data(padd_out_data),
        .rb_r_req(rb_r_req), .rb_status(rb_status), .id_o_rb(id_o_rb),
        .rb_rd_vld(rb_rd_vld), .rb_rd_id(rb_rd_id), .rb_rd_data(rb_rd_data),
        .rb_afull(rb_afull), .rb_full(rb_full), .rb_count(rb_count),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        checks++; if (rb_count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", rb_count); end
        checks++; if (rb_status !== 1'b0) begin errors++; $display("FAIL reset_status got=%b exp=0", rb_status); end
        checks++; if (rb_rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld got=%b exp=0", rb_rd_vld); end
        checks++; if (rb_rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%0h exp=0", rb_rd_data); end
        checks++; if ({err_ovf, err_udf, rb_full, rb_afull} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {err_ovf, err_udf, rb_full, rb_afull}); end
        checks++; if (id_o_rb !== 2'd0) begin errors++; $display("FAIL reset_head_id got=%0d exp=0", id_o_rb); end
    endtask

    task automatic test_basic_order();
        for (int i = 0; i < 4; i++) begin
            padd_out_vld = 1'b1; padd_out_id = WID'(i); padd_out_data = WD'(32'hA0 + i);
            cycle();
            checks++; if (rb_count !== 6'(i + 1)) begin errors++; $display("FAIL basic_push_count got=%0d exp=%0d", rb_count, i + 1); end
        end
        padd_out_vld = 1'b0;
        checks++; if (id_o_rb !== 2'd0) begin errors++; $display("FAIL basic_head_id got=%0d exp=0", id_o_rb); end
        for (int i = 0; i < 4; i++) begin
            rb_r_req = 1'b1;
            cycle();
            checks++; if (rb_rd_vld !== 1'b1) begin errors++; $display("FAIL basic_rd_vld got=%b exp=1", rb_rd_vld); end
            checks++; if (rb_rd_id !== WID'(i)) begin errors++; $display("FAIL basic_rd_id got=%0d exp=%0d", rb_rd_id, i); end
            checks++; if (rb_rd_data !== WD'(32'hA0 + i)) begin errors++; $display("FAIL basic_rd_data got=%0h exp=%0h", rb_rd_data, 32'hA0 + i); end
            checks++; if (rb_count !== 6'(3 - i)) begin errors++; $display("FAIL basic_pop_count got=%0d exp=%0d", rb_count, 3 - i); end
        end
        rb_r_req = 1'b0;
        checks++; if (rb_status !== 1'b0) begin errors++; $display("FAIL basic_status_empty got=%b exp=0", rb_status); end
        cycle();
        checks++; if (rb_rd_vld !== 1'b0) begin errors++; $display("FAIL basic_rd_vld_idle got=%b exp=0", rb_rd_vld); end
        checks++; if (rb_rd_id !== 2'd3) begin errors++; $display("FAIL basic_rd_id_hold got=%0d exp=3", rb_rd_id); end
    endtask

    task automatic test_fill_overflow();
        for (int k = 0; k < DEP; k++) begin
            padd_out_vld = 1'b1; padd_out_id = WID'(k % 4); padd_out_data = WD'(1000 + k);
            cycle();
            checks++; if (rb_afull !== ((k + 1) >= 11)) begin errors++; $display("FAIL fill_afull count=%0d got=%b", k + 1, rb_afull); end
            checks++; if (rb_full !== ((k + 1) == DEP)) begin errors++; $display("FAIL fill_full count=%0d got=%b", k + 1, rb_full); end
        end
        padd_out_data = WD'(9999);
        cycle();
        checks++; if (rb_count !== 6'd32) begin errors++; $display("FAIL ovf_count got=%0d exp=32", rb_count); end
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", err_ovf); end
        // full + push + pop in one cycle
        padd_out_id = 2'd1; padd_out_data = WD'(32'h5555); rb_r_req = 1'b1;
        cycle();
        padd_out_vld = 1'b0;
        checks++; if (rb_count !== 6'd32) begin errors++; $display("FAIL fullpp_count got=%0d exp=32", rb_count); end
        checks++; if (rb_rd_data !== WD'(1000)) begin errors++; $display("FAIL fullpp_rd_data got=%0d exp=1000", rb_rd_data); end
        for (int k = 1; k < DEP; k++) begin
            cycle();
            checks++; if (rb_rd_data !== WD'(1000 + k) || rb_rd_id !== WID'(k % 4)) begin errors++; $display("FAIL drain_data got=%0d/%0d exp=%0d/%0d", rb_rd_data, rb_rd_id, 1000 + k, k % 4); end
        end
        cycle();
        rb_r_req = 1'b0;
        checks++; if (rb_rd_data !== WD'(32'h5555) || rb_rd_id !== 2'd1) begin errors++; $display("FAIL drain_last got=%0h/%0d exp=5555/1", rb_rd_data, rb_rd_id); end
        checks++; if (rb_count !== 6'd0 || err_ovf !== 1'b1 || err_udf !== 1'b0) begin errors++; $display("FAIL drain_end cnt=%0d ovf=%b udf=%b exp 0/1/0", rb_count, err_ovf, err_udf); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf_clear got=%b exp=0", err_ovf); end
    endtask

    task automatic test_empty_push_pop();
        padd_out_vld = 1'b1; padd_out_id = 2'd2; padd_out_data = WD'(77); rb_r_req = 1'b1;
        cycle();
        padd_out_vld = 1'b0; rb_r_req = 1'b0;
        checks++; if (rb_count !== 6'd1) begin errors++; $display("FAIL epp_count got=%0d exp=1", rb_count); end
        checks++; if (rb_rd_vld !== 1'b0) begin errors++; $display("FAIL epp_rd_vld got=%b exp=0", rb_rd_vld); end
        checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL epp_udf got=%b exp=1", err_udf); end
        checks++; if (id_o_rb !== 2'd2 || rb_status !== 1'b1) begin errors++; $display("FAIL epp_head got=%0d/%b exp=2/1", id_o_rb, rb_status); end
        rb_r_req = 1'b1;
        cycle();
        rb_r_req = 1'b0;
        checks++; if (rb_rd_vld !== 1'b1 || rb_rd_data !== WD'(77)) begin errors++; $display("FAIL epp_pop got=%b/%0d exp=1/77", rb_rd_vld, rb_rd_data); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        padd_out_vld = 1'b1; padd_out_id = 2'd0; padd_out_data = WD'(5000);
        cycle();
        for (int k = 1; k <= 100; k++) begin
            padd_out_id = WID'(k % 4); padd_out_data = WD'(5000 + k); rb_r_req = 1'b1;
            cycle();
            checks++; if (rb_rd_data !== WD'(5000 + k - 1) || rb_rd_id !== WID'((k - 1) % 4) || rb_rd_vld !== 1'b1) begin errors++; $display("FAIL stream_data k=%0d got=%0d/%0d exp=%0d/%0d", k, rb_rd_data, rb_rd_id, 5000 + k - 1, (k - 1) % 4); end
            checks++; if (rb_count !== 6'd1) begin errors++; $display("FAIL stream_count k=%0d got=%0d exp=1", k, rb_count); end
        end
        padd_out_vld = 1'b0;
        cycle();
        rb_r_req = 1'b0;
        checks++; if (rb_rd_data !== WD'(5100) || rb_count !== 6'd0) begin errors++; $display("FAIL stream_last got=%0d cnt=%0d exp=5100/0", rb_rd_data, rb_count); end
        checks++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin errors++; $display("FAIL stream_errs got=%b%b exp=00", err_ovf, err_udf); end
    endtask

    task automatic test_flush_reset();
        rb_r_req = 1'b1;
        cycle();
        rb_r_req = 1'b0;
        checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL flush_pre_udf got=%b exp=1", err_udf); end
        for (int k = 0; k < 5; k++) begin
            padd_out_vld = 1'b1; padd_out_id = WID'(k % 4); padd_out_data = WD'(6000 + k);
            cycle();
        end
        flush = 1'b1; rb_r_req = 1'b1; padd_out_data = WD'(6666);
        cycle();
        flush = 1'b0; rb_r_req = 1'b0; padd_out_vld = 1'b0;
        checks++; if (rb_count !== 6'd0 || rb_status !== 1'b0) begin errors++; $display("FAIL flush_count got=%0d/%b exp=0/0", rb_count, rb_status); end
        checks++; if (rb_rd_vld !== 1'b0 || err_udf !== 1'b0 || err_ovf !== 1'b0) begin errors++; $display("FAIL flush_flags got=%b%b%b exp=000", rb_rd_vld, err_udf, err_ovf); end
        checks++; if (id_o_rb !== 2'd0) begin errors++; $display("FAIL flush_head got=%0d exp=0", id_o_rb); end
        for (int k = 0; k < 3; k++) begin
            padd_out_vld = 1'b1; padd_out_id = WID'((k + 1) % 4); padd_out_data = WD'(7000 + k);
            cycle();
        end
        padd_out_vld = 1'b0; rb_r_req = 1'b1;
        cycle();
        rb_r_req = 1'b0;
        checks++; if (rb_rd_vld !== 1'b1 || rb_rd_data !== WD'(7000) || rb_rd_id !== 2'd1) begin errors++; $display("FAIL pre_rst_pop got=%b/%0d/%0d exp=1/7000/1", rb_rd_vld, rb_rd_data, rb_rd_id); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rb_count !== 6'd0 || rb_status !== 1'b0 || id_o_rb !== 2'd0) begin errors++; $display("FAIL rst_async_count got=%0d/%b/%0d exp=0/0/0", rb_count, rb_status, id_o_rb); end
        checks++; if (rb_rd_vld !== 1'b0 || rb_rd_id !== 2'd0 || rb_rd_data !== '0) begin errors++; $display("FAIL rst_async_rd got=%b/%0d/%0d exp=0/0/0", rb_rd_vld, rb_rd_id, rb_rd_data); end
        checks++; if ({rb_afull, rb_full, err_ovf, err_udf} !== 4'b0) begin errors++; $display("FAIL rst_async_flags got=%b exp=0000", {rb_afull, rb_full, err_ovf, err_udf}); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        checks++; if (rb_count !== 6'd0 || rb_rd_vld !== 1'b0) begin errors++; $display("FAIL rst_release got=%0d/%b exp=0/0", rb_count, rb_rd_vld); end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_fill_overflow();
        test_empty_push_pop();
        test_back_to_back();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
